// File: rtl/bsg_reduce_segmented_seq.sv
// bsg_reduce_segmented_seq: multi-cycle segmented xor/and/or/nor reducer
// that sweeps a shared datapath segs_per_cycle_p segments per cycle.
module bsg_reduce_segmented_seq #(
  parameter int segments_p = 1,
  parameter int segment_width_p = 1,
  parameter int segs_per_cycle_p = 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  v_i,
  input  logic [segments_p*segment_width_p-1:0] data_i,
  input  logic [1:0]                            op_i,
  output logic                                  ready_o,
  output logic                                  v_o,
  output logic [segments_p-1:0]                 o,
  input  logic                                  yumi_i
);
  localparam int passes = (segments_p + segs_per_cycle_p - 1) / segs_per_cycle_p;
  localparam int cw = passes > 1 ? $clog2(passes) : 1;
  localparam int dw = segments_p * segment_width_p;
  localparam int pw = passes * segs_per_cycle_p * segment_width_p;
  localparam logic [1:0] idle_s = 2'd0, busy_s = 2'd1, done_s = 2'd2;
  logic [1:0] state;
  logic [cw-1:0] cnt;
  logic [dw-1:0] data_r;
  logic [1:0] op_r;
  logic [pw-1:0] pad;
  logic [segs_per_cycle_p-1:0] lane;
  logic [segments_p-1:0] o_n;
  logic last;
  function automatic logic red(input logic [segment_width_p-1:0] s, input logic [1:0] op);
    return op == 2'd0 ? ^s : op == 2'd1 ? &s : op == 2'd2 ? |s : ~|s;
  endfunction
  assign ready_o = state == idle_s;
  assign v_o = state == done_s;
  assign last = cnt == cw'(passes - 1);
  // zero padding keeps the final pass's spare lanes in range; they are never written to o
  always_comb begin
    pad = '0;
    pad[dw-1:0] = data_r;
    lane = '0;
    for (int l = 0; l < segs_per_cycle_p; l++)
      lane[l] = red(pad[(int'(cnt) * segs_per_cycle_p + l) * segment_width_p +: segment_width_p], op_r);
    o_n = o;
    for (int j = 0; j < segments_p; j++)
      if (cnt == cw'(j / segs_per_cycle_p)) o_n[j] = lane[j % segs_per_cycle_p];
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= idle_s;
      cnt <= '0;
      o <= '0;
      data_r <= '0;
      op_r <= '0;
    end else if (state == idle_s) begin
      if (v_i) begin
        data_r <= data_i;
        op_r <= op_i;
        cnt <= '0;
        o <= '0;
        state <= busy_s;
      end
    end else if (state == busy_s) begin
      o <= o_n;
      cnt <= last ? '0 : cnt + 1'b1;
      state <= last ? done_s : busy_s;
    end else if (yumi_i) begin
      state <= idle_s;
    end
  if (segments_p < 1) $error("segments_p must be >= 1");
  if (segment_width_p < 1) $error("segment_width_p must be >= 1");
  if (segs_per_cycle_p < 1 || segs_per_cycle_p > segments_p) $error("segs_per_cycle_p must be in 1..segments_p");
  yumi_check: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o is low");
endmodule

// File: tb/tb_bsg_reduce_segmented_seq.sv
// tb_bsg_reduce_segmented_seq: scoreboard bench for the segmented reducer (4x4 bits, 3 segs/cycle).
module tb_bsg_reduce_segmented_seq;
  logic clk_i = 0, reset_i = 1, v_i = 0, yumi_i = 0;
  logic [15:0] data_i = '0;
  logic [1:0] op_i = '0;
  logic ready_o, v_o;
  logic [3:0] o;
  int n_chk = 0, n_fail = 0;
  logic [3:0] exp_q[$];
  logic v_d = 0;
  int acc[2];
  int na, y0;

  bsg_reduce_segmented_seq #(.segments_p(4), .segment_width_p(4), .segs_per_cycle_p(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .op_i(op_i),
    .ready_o(ready_o), .v_o(v_o), .o(o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (v_o && !v_d) begin
      if (exp_q.size() == 0) check("scoreboard has entry", 32'(exp_q.size()), 32'd1);
      else check("result o", 32'(o), 32'(exp_q.pop_front()));
    end
    v_d = v_o;
  end

  task automatic start(input logic [15:0] d, input logic [1:0] op, input logic [3:0] e, input bit push);
    @(negedge clk_i);
    check("idle ready_o", 32'(ready_o), 32'd1);
    v_i = 1; data_i = d; op_i = op;
    if (push) exp_q.push_back(e);
    @(negedge clk_i);
    v_i = 0; data_i = 16'hFFFF; op_i = 2'd1;
  endtask

  task automatic run(input logic [15:0] d, input logic [1:0] op, input logic [3:0] e, input int hold);
    start(d, op, e, 1);
    check("busy ready_o t+1", 32'(ready_o), 32'd0);
    check("busy v_o t+1", 32'(v_o), 32'd0);
    @(negedge clk_i);
    check("busy ready_o t+2", 32'(ready_o), 32'd0);
    check("busy v_o t+2", 32'(v_o), 32'd0);
    @(negedge clk_i);
    check("done v_o t+3", 32'(v_o), 32'd1);
    check("done o t+3", 32'(o), 32'(e));
    for (int i = 0; i < hold; i++) begin
      v_i = 1; data_i = 16'hFFFF;
      @(negedge clk_i);
      check("held v_o", 32'(v_o), 32'd1);
      check("held o", 32'(o), 32'(e));
      check("held ready_o", 32'(ready_o), 32'd0);
    end
    v_i = 0; yumi_i = 1;
    @(negedge clk_i);
    yumi_i = 0;
    check("post-yumi v_o", 32'(v_o), 32'd0);
    check("post-yumi ready_o", 32'(ready_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset ready_o", 32'(ready_o), 32'd1);
    check("reset v_o", 32'(v_o), 32'd0);
    check("reset o", 32'(o), 32'd0);
    @(negedge clk_i);
    reset_i = 0;
    run(16'h0F31, 2'd0, 4'b0001, 5);
    run(16'hF0FF, 2'd1, 4'b1011, 0);
    run(16'h0100, 2'd2, 4'b0100, 0);
    run(16'h0100, 2'd3, 4'b1011, 0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1011);
    na = 0; y0 = -1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk_i);
      yumi_i = v_o;
      if (v_o && y0 < 0) y0 = c;
      v_i = na < 2;
      data_i = na == 0 ? 16'h0F31 : 16'hF0FF;
      op_i = na == 0 ? 2'd0 : 2'd1;
      if (v_i && ready_o) begin
        acc[na] = c;
        na++;
      end
    end
    yumi_i = 0; v_i = 0;
    check("b2b accept count", 32'(na), 32'd2);
    if (na == 2) begin
      check("b2b accept spacing", 32'(acc[1] - acc[0]), 32'd4);
      check("b2b accept after yumi", 32'(acc[1]), 32'(y0 + 1));
    end
    start(16'h0F31, 2'd0, 4'b0001, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    check("pre-reset done v_o", 32'(v_o), 32'd1);
    #2 reset_i = 1;
    #1;
    check("async reset in done v_o", 32'(v_o), 32'd0);
    check("async reset in done ready_o", 32'(ready_o), 32'd1);
    check("async reset in done o", 32'(o), 32'd0);
    @(negedge clk_i);
    reset_i = 0;
    start(16'h0F31, 2'd0, 4'b0000, 0);
    check("first busy ready_o", 32'(ready_o), 32'd0);
    #2 reset_i = 1;
    #1;
    check("async reset in busy v_o", 32'(v_o), 32'd0);
    check("async reset in busy ready_o", 32'(ready_o), 32'd1);
    check("async reset in busy o", 32'(o), 32'd0);
    @(negedge clk_i);
    reset_i = 0;
    run(16'h0100, 2'd2, 4'b0100, 0);
    repeat (3) @(negedge clk_i);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
